blink_clock_divider: RTL and testbench

BLINK_CLOCK_DIVIDER -- requirements
Module: blink_clock_divider

---
 rtl/blink_clock_divider_pkg.sv | 22 ++
 rtl/blink_clock_divider_divider.sv | 32 +++
 rtl/blink_clock_divider.sv | 89 ++++++++
 tb/tb_blink_clock_divider.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/blink_clock_divider_pkg.sv
// Shared definitions for the blink clock divider.
//   mode_t     : lamp sequencing mode (LEFT, RIGHT, HAZARD)
//   PATTERN    : lamp pattern per step, innermost lamp in bit 0
//   HEX_*      : active-low 7-segment codes {dp,g,f,e,d,c,b,a} for digits 0..3
package blink_clock_divider_pkg;

  typedef enum logic [1:0] {
    LEFT   = 2'd0,
    RIGHT  = 2'd1,
    HAZARD = 2'd2
  } mode_t;

  localparam logic [2:0] PATTERN [4] = '{3'b000, 3'b001, 3'b011, 3'b111};

  localparam logic [7:0] HEX_0 = 8'hC0;
  localparam logic [7:0] HEX_1 = 8'hF9;
  localparam logic [7:0] HEX_2 = 8'hA4;
  localparam logic [7:0] HEX_3 = 8'hB0;

  localparam logic [7:0] HEX_DIGITS [4] = '{HEX_0, HEX_1, HEX_2, HEX_3};

endpackage

// File: rtl/blink_clock_divider_divider.sv
// Free-running divider producing a one-cycle tick every DIVIDE_BY cycles.
//   clock : sole clock, rising edge
//   reset : synchronous, active-high; clears the count and the tick
//   tick  : registered pulse, first asserted DIVIDE_BY cycles after reset release
module clock_divider #(
  parameter int unsigned DIVIDE_BY = 1000000
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam logic [31:0] LAST = DIVIDE_BY - 32'd1;

  logic [31:0] count;
  logic        wrap;

  assign wrap = (count == LAST);

  // The tick is registered from the terminal count, so it is low straight out
  // of reset and, with DIVIDE_BY=1, stays high on every cycle afterwards.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
      tick  <= 1'b0;
    end else begin
      count <= wrap ? '0 : count + 32'd1;
      tick  <= wrap;
    end
  end

endmodule

// File: rtl/blink_clock_divider.sv
// Turn-signal / hazard lamp sequencer driven by a divided tick.
//   clock       : sole clock, rising edge
//   reset       : synchronous, active-high
//   hazards     : 1 = hazard mode (overrides turn direction), asynchronous input
//   turn_change : 1 = left, 0 = right, asynchronous input
//   left_leds   : left lamp group, bit0 innermost
//   right_leds  : right lamp group, bit0 innermost
//   hex         : active-low 7-segment digit of the current step
//   tick        : divider terminal-count pulse
module blink_clock_divider
  import blink_clock_divider_pkg::*;
#(
  parameter int unsigned DIVIDE_BY = 1000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       hazards,
  input  logic       turn_change,
  output logic [2:0] left_leds,
  output logic [2:0] right_leds,
  output logic [7:0] hex,
  output logic       tick
);

  logic       hazards_p0, hazards_p1;
  logic       turn_p0, turn_p1;
  mode_t      mode, mode_next;
  logic [1:0] step, step_next;
  logic [2:0] pattern;

  function automatic logic [2:0] lamps_for(input mode_t m, input mode_t side,
                                           input logic [2:0] pat);
    return (m == side || m == HAZARD) ? pat : 3'b000;
  endfunction

  clock_divider #(.DIVIDE_BY(DIVIDE_BY)) u_divider (
    .clock (clock),
    .reset (reset),
    .tick  (tick)
  );

  // Stage p0 -> p1: two-flop synchronizers on the asynchronous mode inputs
  always_ff @(posedge clock) begin
    if (reset) begin
      hazards_p0 <= 1'b0;
      hazards_p1 <= 1'b0;
      turn_p0    <= 1'b0;
      turn_p1    <= 1'b0;
    end else begin
      hazards_p0 <= hazards;
      hazards_p1 <= hazards_p0;
      turn_p0    <= turn_change;
      turn_p1    <= turn_p0;
    end
  end

  always_comb begin
    mode_next = RIGHT;
    if (hazards_p1)   mode_next = HAZARD;
    else if (turn_p1) mode_next = LEFT;
  end

  // A mode change restarts the sweep from the inner lamp and wins over a tick.
  always_comb begin
    step_next = step;
    if (mode != mode_next) step_next = 2'd0;
    else if (tick)         step_next = step + 2'd1;
  end

  assign pattern = PATTERN[step_next];

  // Stage p1 -> outputs: mode, step and lamp/digit decode all update together
  always_ff @(posedge clock) begin
    if (reset) begin
      mode       <= RIGHT;
      step       <= 2'd0;
      left_leds  <= 3'b000;
      right_leds <= 3'b000;
      hex        <= HEX_0;
    end else begin
      mode       <= mode_next;
      step       <= step_next;
      left_leds  <= lamps_for(mode_next, LEFT, pattern);
      right_leds <= lamps_for(mode_next, RIGHT, pattern);
      hex        <= HEX_DIGITS[step_next];
    end
  end

endmodule

// File: tb/tb_blink_clock_divider.sv
// Bench for blink_clock_divider: two instances (DIVIDE_BY=1 and 4) share the
// stimulus; a cycle-level model derives every expected output.
module tb_blink_clock_divider;

  logic clk, reset, hazards, turn_change;
  logic [2:0] l1, r1, l4, r4;
  logic [7:0] h1, h4;
  logic t1, t4;

  int n_checks = 0;
  int n_pass   = 0;

  blink_clock_divider #(.DIVIDE_BY(1)) dut1 (
    .clock(clk), .reset(reset), .hazards(hazards), .turn_change(turn_change),
    .left_leds(l1), .right_leds(r1), .hex(h1), .tick(t1));

  blink_clock_divider #(.DIVIDE_BY(4)) dut4 (
    .clock(clk), .reset(reset), .hazards(hazards), .turn_change(turn_change),
    .left_leds(l4), .right_leds(r4), .hex(h4), .tick(t4));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0=left 1=right 2=hazard. Mode after an edge is decided by the
  // inputs sampled two edges earlier; ticks land on cycle k>0, k%N==0 after reset.
  logic [2:0] pat_m [4] = '{3'b000, 3'b001, 3'b011, 3'b111};
  logic [7:0] hex_m [4] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0};
  int ndiv [2] = '{1, 4};
  int k_m, mode_m;
  int step_m [2];
  bit tick_m [2];
  bit hist_h [2];
  bit hist_t [2];
  bit valid = 0;

  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        k_m = 0; mode_m = 1; valid = 1;
        hist_h = '{0, 0}; hist_t = '{0, 0};
        for (int i = 0; i < 2; i++) begin
          step_m[i] = 0; tick_m[i] = 0;
        end
      end else begin
        int nm;
        nm = hist_h[1] ? 2 : (hist_t[1] ? 0 : 1);
        hist_h[1] = hist_h[0]; hist_h[0] = hazards;
        hist_t[1] = hist_t[0]; hist_t[0] = turn_change;
        k_m++;
        for (int i = 0; i < 2; i++) begin
          if (nm != mode_m)  step_m[i] = 0;
          else if (tick_m[i]) step_m[i] = (step_m[i] + 1) % 4;
          tick_m[i] = (k_m % ndiv[i] == 0);
        end
        mode_m = nm;
      end
    end
  end

  function automatic logic [2:0] exp_left(input int i);
    return (mode_m == 0 || mode_m == 2) ? pat_m[step_m[i]] : 3'b000;
  endfunction
  function automatic logic [2:0] exp_right(input int i);
    return (mode_m == 1 || mode_m == 2) ? pat_m[step_m[i]] : 3'b000;
  endfunction

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (valid) begin
        check("m1.left",  8'(l1), 8'(exp_left(0)));
        check("m1.right", 8'(r1), 8'(exp_right(0)));
        check("m1.hex",   h1,     hex_m[step_m[0]]);
        check("m1.tick",  8'(t1), 8'(tick_m[0]));
        check("m4.left",  8'(l4), 8'(exp_left(1)));
        check("m4.right", 8'(r4), 8'(exp_right(1)));
        check("m4.hex",   h4,     hex_m[step_m[1]]);
        check("m4.tick",  8'(t4), 8'(tick_m[1]));
      end
    end
  end

  // ---------------- directed stimulus with literal expectations ----------------
  initial begin
    reset = 1'b1; hazards = 1'b0; turn_change = 1'b1;
    repeat (3) @(negedge clk);
    check("rst.left1",  8'(l1), 8'h00);
    check("rst.right1", 8'(r1), 8'h00);
    check("rst.hex1",   h1,     8'hC0);
    check("rst.tick1",  8'(t1), 8'h00);
    check("rst.tick4",  8'(t4), 8'h00);
    reset = 1'b0;

    // Left sweep (DIVIDE_BY=1) and tick spacing (DIVIDE_BY=4)
    for (int e = 1; e <= 9; e++) begin
      @(negedge clk);
      case (e)
        3: begin check("lft.l0", 8'(l1), 8'h00); check("lft.h0", h1, 8'hC0); end
        4: begin check("lft.l1", 8'(l1), 8'h01); check("lft.h1", h1, 8'hF9); end
        5: check("lft.l2", 8'(l1), 8'h03);
        6: begin check("lft.l3", 8'(l1), 8'h07); check("lft.h3", h1, 8'hB0); end
        7: check("lft.wrap", 8'(l1), 8'h00);
        default: ;
      endcase
      if (e >= 3) check("lft.right", 8'(r1), 8'h00);
      check("tick4.pulse", 8'(t4), (e % 4 == 0) ? 8'h01 : 8'h00);
    end

    // Step is 2 here; switch to right
    turn_change = 1'b0;
    for (int e = 10; e <= 16; e++) begin
      @(negedge clk);
      case (e)
        12: begin check("chg.hex", h1, 8'hC0); check("chg.l", 8'(l1), 8'h00);
                  check("chg.r", 8'(r1), 8'h00); end
        13: begin check("rgt.r1", 8'(r1), 8'h01); check("rgt.h1", h1, 8'hF9); end
        14: begin check("rgt.r2", 8'(r1), 8'h03); check("rgt.h2", h1, 8'hA4); end
        15: begin check("rgt.r3", 8'(r1), 8'h07); check("rgt.h3", h1, 8'hB0); end
        16: begin check("rgt.r0", 8'(r1), 8'h00); check("rgt.h0", h1, 8'hC0); end
        default: ;
      endcase
    end

    hazards = 1'b1;
    for (int e = 17; e <= 22; e++) begin
      @(negedge clk);
      case (e)
        19: begin check("haz.l0", 8'(l1), 8'h00); check("haz.r0", 8'(r1), 8'h00);
                  check("haz.h0", h1, 8'hC0); end
        20: begin check("haz.l1", 8'(l1), 8'h01); check("haz.r1", 8'(r1), 8'h01); end
        22: begin check("haz.l3", 8'(l1), 8'h07); check("haz.r3", 8'(r1), 8'h07);
                  check("haz.h3", h1, 8'hB0); end
        default: ;
      endcase
    end

    // Reset at step 3
    reset = 1'b1;
    @(negedge clk);
    check("mrst.l",  8'(l1), 8'h00);
    check("mrst.r",  8'(r1), 8'h00);
    check("mrst.h",  h1,     8'hC0);
    check("mrst.t4", 8'(t4), 8'h00);
    reset = 1'b0;

    // Mixed mode changes, with one more reset, checked by the model
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (c % 7 == 0) begin
        hazards     = ($urandom_range(0, 3) == 0);
        turn_change = 1'($urandom_range(0, 1));
      end
      if (c == 150) reset = 1'b1;
      if (c == 152) reset = 1'b0;
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
